// File: rtl/mpw_wb_pkg.sv
// Shared constants and helpers for the mpw2304c_mp Wishbone register bank.
package mpw_wb_pkg;

  localparam logic [7:0] ID_OFS       = 8'h00;
  localparam logic [7:0] GPIO_OUT_OFS = 8'h04;
  localparam logic [7:0] GPIO_OEB_OFS = 8'h08;
  localparam logic [7:0] GPIO_IN_OFS  = 8'h0C;
  localparam logic [7:0] TMR_LOAD_OFS = 8'h10;
  localparam logic [7:0] TMR_CTRL_OFS = 8'h14;
  localparam logic [7:0] TMR_CNT_OFS  = 8'h18;
  localparam logic [7:0] IRQSTS_OFS   = 8'h1C;
  localparam logic [7:0] IRQEN_OFS    = 8'h20;

  localparam int IRQ_TMR  = 0;
  localparam int IRQ_RISE = 1;
  localparam int IRQ_FALL = 2;

  localparam int CTRL_EN         = 0;
  localparam int CTRL_AUTORELOAD = 1;

  // Replace only the bytes whose select bit is set.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    for (int b = 0; b < 4; b++)
      res[8*b +: 8] = sel[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
    return res;
  endfunction

endpackage

// File: rtl/mpw_wb_regbank_sync2.sv
// Two-flop synchroniser for asynchronous pad inputs.
module mpw_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_p0, sync_p1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/mpw_wb_regbank.sv
// Wishbone classic slave: GPIO pad control, down-counter timer and user IRQs.
module mpw_wb_regbank
  import mpw_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          NIO       = 17,
  parameter logic [31:0] ID_VALUE  = 32'h2304_C001
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_ni,
  input  logic           wbs_cyc_i,
  input  logic           wbs_stb_i,
  input  logic           wbs_we_i,
  input  logic [3:0]     wbs_sel_i,
  input  logic [31:0]    wbs_adr_i,
  input  logic [31:0]    wbs_dat_i,
  output logic           wbs_ack_o,
  output logic [31:0]    wbs_dat_o,
  input  logic [NIO-1:0] gpio_in,
  output logic [NIO-1:0] gpio_out,
  output logic [NIO-1:0] gpio_oeb,
  output logic [2:0]     irq
);

  logic           ack_q;
  logic [31:0]    dat_q;
  logic [NIO-1:0] gpio_out_q, gpio_oeb_q, gin_s;
  logic [31:0]    tmr_load_q, tmr_cnt_q;
  logic [1:0]     tmr_ctrl_q;
  logic [2:0]     irq_sts_q, irq_en_q, irq_q;
  logic           gin0_d;

  logic        hit, commit, wr;
  logic [7:0]  ofs;
  logic [31:0] rd_mux;
  logic [31:0] out_m, oeb_m, load_m, ctrl_m, en_m;
  logic [2:0]  sts_clr, sts_set;
  logic        tmr_en, tmr_ar, expire;
  logic        unused_bits;

  assign hit    = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign commit = hit & ~ack_q;
  assign wr     = commit & wbs_we_i;
  assign ofs    = {wbs_adr_i[7:2], 2'b00};

  assign out_m  = byte_merge(32'(gpio_out_q), wbs_dat_i, wbs_sel_i);
  assign oeb_m  = byte_merge(32'(gpio_oeb_q), wbs_dat_i, wbs_sel_i);
  assign load_m = byte_merge(tmr_load_q, wbs_dat_i, wbs_sel_i);
  assign ctrl_m = byte_merge(32'(tmr_ctrl_q), wbs_dat_i, wbs_sel_i);
  assign en_m   = byte_merge(32'(irq_en_q), wbs_dat_i, wbs_sel_i);

  assign unused_bits = ^{wbs_adr_i[1:0], out_m[31:NIO], oeb_m[31:NIO],
                         ctrl_m[31:2], en_m[31:3]};

  mpw_sync2 #(.WIDTH(NIO)) u_gin_sync (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_ni),
    .d     (gpio_in),
    .q     (gin_s)
  );

  assign tmr_en = tmr_ctrl_q[CTRL_EN];
  assign tmr_ar = tmr_ctrl_q[CTRL_AUTORELOAD];
  assign expire = tmr_en & (tmr_cnt_q == 32'd0);

  // W1C only affects bits whose byte lane is enabled; hardware sets win.
  assign sts_clr = (wr && ofs == IRQSTS_OFS && wbs_sel_i[0]) ? wbs_dat_i[2:0] : 3'b000;
  always_comb begin
    sts_set           = 3'b000;
    sts_set[IRQ_TMR]  = expire;
    sts_set[IRQ_RISE] = gin_s[0] & ~gin0_d;
    sts_set[IRQ_FALL] = ~gin_s[0] & gin0_d;
  end

  always_comb begin
    rd_mux = '0;
    case (ofs)
      ID_OFS:       rd_mux = ID_VALUE;
      GPIO_OUT_OFS: rd_mux = 32'(gpio_out_q);
      GPIO_OEB_OFS: rd_mux = 32'(gpio_oeb_q);
      GPIO_IN_OFS:  rd_mux = 32'(gin_s);
      TMR_LOAD_OFS: rd_mux = tmr_load_q;
      TMR_CTRL_OFS: rd_mux = 32'(tmr_ctrl_q);
      TMR_CNT_OFS:  rd_mux = tmr_cnt_q;
      IRQSTS_OFS:   rd_mux = 32'(irq_sts_q);
      IRQEN_OFS:    rd_mux = 32'(irq_en_q);
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      ack_q      <= 1'b0;
      dat_q      <= '0;
      gpio_out_q <= '0;
      gpio_oeb_q <= '1;
      tmr_load_q <= '0;
      tmr_cnt_q  <= '0;
      tmr_ctrl_q <= '0;
      irq_sts_q  <= '0;
      irq_en_q   <= '0;
      irq_q      <= '0;
      gin0_d     <= 1'b0;
    end else begin
      ack_q  <= commit;
      dat_q  <= commit ? rd_mux : 32'd0;
      gin0_d <= gin_s[0];

      if (wr && ofs == GPIO_OUT_OFS) gpio_out_q <= out_m[NIO-1:0];
      if (wr && ofs == GPIO_OEB_OFS) gpio_oeb_q <= oeb_m[NIO-1:0];
      if (wr && ofs == IRQEN_OFS)    irq_en_q   <= en_m[2:0];

      // A LOAD write preempts this cycle's decrement or reload.
      if (wr && ofs == TMR_LOAD_OFS) begin
        tmr_load_q <= load_m;
        tmr_cnt_q  <= load_m;
      end else if (tmr_en) begin
        if (tmr_cnt_q != 32'd0) tmr_cnt_q <= tmr_cnt_q - 32'd1;
        else if (tmr_ar)        tmr_cnt_q <= tmr_load_q;
      end

      if (wr && ofs == TMR_CTRL_OFS) tmr_ctrl_q <= ctrl_m[1:0];
      else if (expire && !tmr_ar)    tmr_ctrl_q[CTRL_EN] <= 1'b0;

      irq_sts_q <= (irq_sts_q & ~sts_clr) | sts_set;
      irq_q     <= irq_sts_q & irq_en_q;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign gpio_out  = gpio_out_q;
  assign gpio_oeb  = gpio_oeb_q;
  assign irq       = irq_q;

endmodule
